pwm_capture: RTL and testbench
==============================

# pwm_capture

Input-capture block that receives a PWM waveform, such as the output of the team's up/down-counter PWM generator, and measures it. It synchronises the external `pwm_in`, detects edges, and measures the period (rising edge to rising edge) and the high time (rising edge to falling edge) in `Clock` cycles. Each completed period produces a one-cycle `meas_valid` strobe. It sits at the feedback/monitor end of the PWM path, so firmware or a control loop can check the duty cycle actually produced.

## Interface
- `WIDTH`, 12: width of the measurement counter and of the outputs (matches the 12-bit PWM datapath).
- `Clock`  in  1  system clock; all logic uses the rising edge.
- `Rst`  in  1  reset; synchronous, active-high.
- `En`  in  1  capture enable. Low: state forced to IDLE, counter cleared, no strobes.
- `pwm_in`  in  1  PWM input; asynchronous to `Clock`.
- `period`  out  WIDTH  last measured period in cycles.
- `high_time`  out  WIDTH  last measured high time in cycles.
- `meas_valid`  out  1  one-cycle strobe; `period`/`high_time` updated this cycle.
- `stuck`  out  1  level; no edge seen for 2^WIDTH−1 cycles.
- `stuck_level`  out  1  synchronised `pwm_in` level when `stuck` set (0 = 0 % duty, 1 = 100 % duty).

## Operation
- Front end: 2-flop synchroniser to `pwm_s`, plus a delay flop to `pwm_d`.
  - `rise` = `pwm_s & ~pwm_d`.
  - `fall` = `~pwm_s & pwm_d`.
- States:
  - IDLE: waiting for the first edge.
  - HIGH: between a rise and a fall.
  - LOW: between a fall and the next rise.
- Counter `cnt`, WIDTH bits:
  - On `rise`, loads 1.
  - Otherwise increments, saturating at 2^WIDTH−1.
- Transitions:
  - IDLE, `rise` → HIGH. `cnt`=1. No strobe, because the first edge has no reference.
  - HIGH, `fall` → LOW. Internal `high_lat` ← `cnt`.
  - LOW, `rise` → HIGH.
    - `period` ← `cnt`.
    - `high_time` ← `high_lat`.
    - `meas_valid` = 1 for one cycle.
    - `cnt` ← 1.
  - HIGH or LOW, `cnt` = 2^WIDTH−1 with no edge → IDLE. `stuck` ← 1, `stuck_level` ← `pwm_s`.
  - Any state, `En` = 0 → IDLE. `cnt` ← 0, `stuck` ← 0.
  - `fall` in IDLE is ignored.
- `stuck` clears on the next `rise`. `stuck_level` holds its value.
- `period` and `high_time` hold their last values until the next strobe. They are not cleared by `stuck` or by `En`.
- Result for an ideal input with period P and high time N (both in cycles): `period` = P, `high_time` = N.
- Minimum measurable input: N = 1, P = 2.

## Timing
- Reset values: all outputs 0, synchroniser and delay flops 0, state IDLE, `cnt` 0.
- Latency: the `Clock` edge that first samples a rising `pwm_in` is edge k. `rise` is true in the cycle after edge k+1. `meas_valid`, `period` and `high_time` update at edge k+2.
- Simultaneous events:
  - `rise` in the same cycle that `cnt` saturates: `rise` wins. A valid measurement is produced from LOW, or HIGH is entered from IDLE, and `stuck` is not set.
  - `Rst` has priority over `En` and over all edges.
- Reset mid-period: the measurement in flight is discarded and no strobe is issued.
- If `pwm_in` is high when `Rst` deasserts, the synchroniser reset value of 0 makes it register as a rise. That rise counts as the first edge, with no strobe.
- `En` rising is treated like reset release: the first edge afterwards produces no strobe.

## Structure
- Shared package `pwm_pkg`:
  - WIDTH default constant (12).
  - State enum `cap_state_t` {IDLE, HIGH, LOW}.
  - Counter saturation constant.
- Sub-module `pwm_sync_edge`: 2-flop synchroniser, delay flop, `rise`/`fall` outputs, synchronous reset to 0.
- `pwm_capture` contains the FSM, counter and output registers.

## Test plan
- Steady PWM with high 300 cycles, low 700 cycles, `En` = 1:
  - the first rise gives no strobe;
  - each later rise gives `meas_valid` for 1 cycle with `period` = 1000 and `high_time` = 300;
  - strobes are 1000 cycles apart.
- Latency check: one rising `pwm_in` step; `meas_valid` asserts exactly 2 edges after the first sampling edge. Check with a prior LOW state established.
- Boundary duty: 1-high/1-low input gives `period` = 2, `high_time` = 1.
- Constant input, both levels:
  - `pwm_in` held high after one rise: `stuck` = 1 after 4095 cycles, with `stuck_level` = 1.
  - `pwm_in` held low: `stuck` = 1, with `stuck_level` = 0.
  - Resuming 50/100 PWM: `stuck` clears at the first rise, and the first strobe comes one period later with `period` = 100.
- `Rst` pulse mid-high phase:
  - all outputs are 0 the next cycle;
  - the next rise produces no strobe;
  - the following rise gives correct values.
- `En` dropped for 10 cycles mid-stream:
  - no strobes while low;
  - `period`/`high_time` retain their old values;
  - after `En` returns, the first rise is a reference edge and the second gives a correct strobe.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared width, saturation value and FSM state type for the PWM capture block.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 12;

    function automatic int unsigned sat_value(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned PWM_CNT_MAX = sat_value(PWM_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM input into the clock domain and flags its edges.
module pwm_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_pwm_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // r_meta may go metastable; only r_sync and r_dly feed the edge logic
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_pwm_s = r_sync;
    assign o_rise  = r_sync & ~r_dly;
    assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform in clock cycles,
// and flags a missing-edge condition when the input stays constant too long.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_pwm_in,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high_time,
    output logic             o_meas_valid,
    output logic             o_stuck,
    output logic             o_stuck_level
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_value(WIDTH));

    logic w_pwm_s;
    logic w_rise;
    logic w_fall;
    logic w_sat;

    cap_state_t r_state;
    cap_state_t w_state_next;
    logic       w_strobe;
    logic       w_latch_high;
    logic       w_set_stuck;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_high_lat;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_stuck;
    logic             r_stuck_level;

    pwm_sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pwm   (i_pwm_in),
        .o_pwm_s (w_pwm_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_sat = (r_cnt == CNT_MAX);

    // An edge always beats saturation, so a period of exactly CNT_MAX is still measured
    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        w_latch_high = 1'b0;
        w_set_stuck  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_next = LOW;
                    w_latch_high = 1'b1;
                end else if (w_sat) begin
                    w_state_next = IDLE;
                    w_set_stuck  = 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                    w_strobe     = 1'b1;
                end else if (w_sat) begin
                    w_state_next = IDLE;
                    w_set_stuck  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Measurement results survive En drops and stuck events; only reset clears them
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_high_lat    <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_meas_valid  <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else if (!i_en) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_meas_valid <= w_strobe;
            if (w_rise) begin
                r_cnt <= WIDTH'(1);
            end else if (!w_sat) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (w_latch_high) begin
                r_high_lat <= r_cnt;
            end
            if (w_strobe) begin
                r_period    <= r_cnt;
                r_high_time <= r_high_lat;
            end
            if (w_set_stuck) begin
                r_stuck       <= 1'b1;
                r_stuck_level <= w_pwm_s;
            end else if (w_rise) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign o_period      = r_period;
    assign o_high_time   = r_high_time;
    assign o_meas_valid  = r_meas_valid;
    assign o_stuck       = r_stuck;
    assign o_stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus random PWM,
// compared every cycle against an event-level model of the capture rules.
module tb_pwm_capture;

    localparam int W   = 12;
    localparam int SAT = 4095;

    typedef enum {M_IDLE, M_HIGH, M_LOW} modelMode_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          en    = 1'b0;
    logic          pwmIn = 1'b0;
    logic [W-1:0]  period;
    logic [W-1:0]  highTime;
    logic          measValid;
    logic          stuck;
    logic          stuckLevel;

    pwm_capture #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_pwm_in      (pwmIn),
        .o_period      (period),
        .o_high_time   (highTime),
        .o_meas_valid  (measValid),
        .o_stuck       (stuck),
        .o_stuck_level (stuckLevel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model state: edges are numbered, the input sampled at each edge is kept,
    // and measurements are differences between edge numbers of detected events.
    int         edgeNo   = 0;
    int         rstEdge  = 0;
    bit         sampAt[int];
    modelMode_t mode     = M_IDLE;
    int         riseEdge = 0;
    int         expHighLat    = 0;
    int         expPeriod     = 0;
    int         expHighTime   = 0;
    bit         expValid      = 1'b0;
    bit         expStuck      = 1'b0;
    bit         expStuckLevel = 1'b0;
    int         strobeEdges[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeNo);
        else
            passes++;
    endtask

    task automatic applyStimulus(input logic lvl, input int n);
        pwmIn = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyPwm(input int h, input int l);
        applyStimulus(1'b1, h);
        applyStimulus(1'b0, l);
    endtask

    // Synchronised level seen by the capture logic: input sampled at edge j, or 0 if reset since
    function automatic bit levelAt(input int j);
        if (j <= rstEdge || j < 1) return 1'b0;
        return sampAt[j];
    endfunction

    // Reference model: the level seen just before edge m is the input sampled at edge m-2
    always @(posedge clk) begin
        bit s, d, rise, fall;
        int elapsed;
        edgeNo++;
        sampAt[edgeNo] = pwmIn;
        s    = levelAt(edgeNo - 2);
        d    = levelAt(edgeNo - 3);
        rise = s & ~d;
        fall = ~s & d;
        elapsed  = (edgeNo - riseEdge > SAT) ? SAT : edgeNo - riseEdge;
        expValid = 1'b0;
        if (rst) begin
            rstEdge       = edgeNo;
            mode          = M_IDLE;
            expHighLat    = 0;
            expPeriod     = 0;
            expHighTime   = 0;
            expStuck      = 1'b0;
            expStuckLevel = 1'b0;
        end else if (!en) begin
            mode     = M_IDLE;
            expStuck = 1'b0;
        end else begin
            case (mode)
                M_IDLE: if (rise) begin
                    mode     = M_HIGH;
                    riseEdge = edgeNo;
                    expStuck = 1'b0;
                end
                M_HIGH: if (fall) begin
                    mode       = M_LOW;
                    expHighLat = elapsed;
                end else if (elapsed == SAT) begin
                    mode          = M_IDLE;
                    expStuck      = 1'b1;
                    expStuckLevel = s;
                end
                M_LOW: if (rise) begin
                    mode        = M_HIGH;
                    expValid    = 1'b1;
                    expPeriod   = elapsed;
                    expHighTime = expHighLat;
                    riseEdge    = edgeNo;
                end else if (elapsed == SAT) begin
                    mode          = M_IDLE;
                    expStuck      = 1'b1;
                    expStuckLevel = s;
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model, half a cycle after the active edge
    always @(negedge clk) begin
        if (edgeNo > 0) begin
            checkOutput("meas_valid",  measValid,  expValid);
            checkOutput("period",      period,     expPeriod);
            checkOutput("high_time",   highTime,   expHighTime);
            checkOutput("stuck",       stuck,      expStuck);
            checkOutput("stuck_level", stuckLevel, expStuckLevel);
            if (measValid === 1'b1) strobeEdges.push_back(edgeNo);
        end
    end

    initial begin
        int h, l, r, n;
        rst = 1'b1; en = 1'b0; pwmIn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_period",      period,     0);
        checkOutput("reset_high_time",   highTime,   0);
        checkOutput("reset_meas_valid",  measValid,  0);
        checkOutput("reset_stuck",       stuck,      0);
        checkOutput("reset_stuck_level", stuckLevel, 0);
        rst = 1'b0; en = 1'b1;
        applyStimulus(1'b0, 20);

        // Steady 300/700 waveform
        strobeEdges.delete();
        repeat (4) applyPwm(300, 700);
        checkOutput("steady_strobe_count", strobeEdges.size(), 3);
        for (int i = 1; i < strobeEdges.size(); i++)
            checkOutput("steady_spacing", strobeEdges[i] - strobeEdges[i-1], 1000);
        checkOutput("steady_period",    period,   1000);
        checkOutput("steady_high_time", highTime, 300);

        // Latency from a LOW state: strobe lands on the third sampling edge
        pwmIn = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("latency_early", measValid, 0);
        @(posedge clk); #1;
        checkOutput("latency_strobe", measValid, 1);
        checkOutput("latency_period", period, 1000);
        @(negedge clk);
        applyStimulus(1'b1, 40);
        applyStimulus(1'b0, 10);

        // Minimum measurable waveform
        repeat (12) applyPwm(1, 1);
        checkOutput("min_period",    period,   2);
        checkOutput("min_high_time", highTime, 1);

        // Held high after a rise
        applyStimulus(1'b0, 10);
        pwmIn = 1'b1;
        repeat (SAT + 2) @(posedge clk);
        #1 checkOutput("stuck_high_early", stuck, 0);
        @(posedge clk); #1;
        checkOutput("stuck_high", stuck, 1);
        checkOutput("stuck_high_level", stuckLevel, 1);
        @(negedge clk);
        applyStimulus(1'b1, 20);

        // Held low after a short pulse
        applyStimulus(1'b0, 20);
        applyPwm(20, 4200);
        checkOutput("stuck_low", stuck, 1);
        checkOutput("stuck_low_level", stuckLevel, 0);

        // Resume 50/100: stuck clears at the first rise, which is only a reference
        pwmIn = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("resume_stuck_hold", stuck, 1);
        @(posedge clk); #1;
        checkOutput("resume_stuck_clear", stuck, 0);
        checkOutput("resume_no_strobe", measValid, 0);
        @(negedge clk);
        applyStimulus(1'b1, 47);
        applyStimulus(1'b0, 50);
        repeat (2) applyPwm(50, 50);
        checkOutput("resume_period",    period,   100);
        checkOutput("resume_high_time", highTime, 50);

        // Reset pulse in the middle of a high phase
        applyStimulus(1'b1, 20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_period",      period,     0);
        checkOutput("midrst_high_time",   highTime,   0);
        checkOutput("midrst_meas_valid",  measValid,  0);
        checkOutput("midrst_stuck",       stuck,      0);
        checkOutput("midrst_stuck_level", stuckLevel, 0);
        rst = 1'b0;
        strobeEdges.delete();
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 50);
        checkOutput("midrst_no_strobe", strobeEdges.size(), 0);
        repeat (3) applyPwm(50, 50);
        checkOutput("midrst_period_after",    period,   100);
        checkOutput("midrst_high_time_after", highTime, 50);

        // En dropped for 10 cycles during a low phase
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 20);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("en_low_no_strobe", measValid, 0);
        end
        checkOutput("en_low_period",    period,   100);
        checkOutput("en_low_high_time", highTime, 50);
        en = 1'b1;
        strobeEdges.delete();
        applyStimulus(1'b0, 30);
        repeat (2) applyPwm(50, 50);
        checkOutput("en_return_strobes", strobeEdges.size(), 1);
        checkOutput("en_return_period",  period, 100);

        // Rise in the very cycle the counter saturates
        applyPwm(100, 3995);
        pwmIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat_rise_strobe", measValid, 1);
        checkOutput("sat_rise_period", period, SAT);
        checkOutput("sat_rise_stuck",  stuck, 0);
        @(negedge clk);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 20);

        // Random waveforms with occasional reset and enable drops
        for (int seg = 0; seg < 40; seg++) begin
            h = $urandom_range(1, 150);
            l = $urandom_range(1, 150);
            r = $urandom_range(0, 19);
            n = $urandom_range(1, 12);
            if (r == 0) begin
                rst = 1'b1;
                applyStimulus(pwmIn, (n % 3) + 1);
                rst = 1'b0;
            end else if (r < 3) begin
                en = 1'b0;
                applyStimulus(pwmIn, n);
                en = 1'b1;
            end
            applyPwm(h, l);
        end
        applyStimulus(1'b0, 10);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
